// File: rtl/sm_controller_if.sv
// Control bundle between the instruction decoder/IR side and the sm_controller sequencer.
// The datapath control outputs also travel on this bundle.
interface sm_controller_if #(
    parameter int CNT_W = 16
);
    // Handshake: an instruction is accepted on a rising clk edge where start=1 and waiting=1;
    // waiting stays 0 until that instruction completes, so start carries no meaning while waiting=0.
    logic             start;
    logic [2:0]       opcode;
    logic [1:0]       ALU_op;
    logic             waiting;
    logic [1:0]       reg_sel;
    logic [1:0]       wb_sel;
    logic             w_en;
    logic             en_A;
    logic             en_B;
    logic             en_C;
    logic             en_status;
    logic             sel_A;
    logic             sel_B;
    logic             illegal;
    logic [CNT_W-1:0] retired;

    modport master (
        output start, opcode, ALU_op,
        input  waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
               sel_A, sel_B, illegal, retired
    );

    modport slave (
        input  start, opcode, ALU_op,
        output waiting, reg_sel, wb_sel, w_en, en_A, en_B, en_C, en_status,
               sel_A, sel_B, illegal, retired
    );
endinterface

// File: rtl/sm_controller.sv
// Moore sequencer for the Simple RISC Machine: one instruction per accepted start.
// The captured opcode steers the path; the retired-instruction counter saturates.
module sm_controller #(
    parameter int CNT_W = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    sm_controller_if.slave bus,
    output logic [2:0]     dbg_state
);
    typedef enum logic [2:0] {
        S_WAIT   = 3'd0,
        S_DECODE = 3'd1,
        S_GET_A  = 3'd2,
        S_GET_B  = 3'd3,
        S_EXEC   = 3'd4,
        S_WR_REG = 3'd5,
        S_WR_IMM = 3'd6
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [4:0]       op_q;
    logic             illegal_q;
    logic [CNT_W-1:0] retired_q;
    logic             accept;
    logic             set_illegal;
    logic             retire;

    logic is_mov_imm;
    logic is_mov_reg;
    logic is_alu;
    logic is_cmp;

    // Decode works only from the captured op so late changes on the decoder fields cannot reroute.
    assign is_mov_imm = (op_q == 5'b110_10);
    assign is_mov_reg = (op_q == 5'b110_00);
    assign is_alu     = (op_q[4:2] == 3'b101);
    assign is_cmp     = (op_q == 5'b101_01);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= S_WAIT;
            op_q      <= '0;
            illegal_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state <= state_next;
            if (accept) begin
                op_q      <= {bus.opcode, bus.ALU_op};
                illegal_q <= 1'b0;
            end
            if (set_illegal) begin
                illegal_q <= 1'b1;
            end
            if (retire && (retired_q != {CNT_W{1'b1}})) begin
                retired_q <= retired_q + 1'b1;
            end
        end
    end

    always_comb begin
        state_next    = state;
        accept        = 1'b0;
        set_illegal   = 1'b0;
        retire        = 1'b0;
        bus.waiting   = 1'b0;
        bus.reg_sel   = 2'b00;
        bus.wb_sel    = 2'b00;
        bus.w_en      = 1'b0;
        bus.en_A      = 1'b0;
        bus.en_B      = 1'b0;
        bus.en_C      = 1'b0;
        bus.en_status = 1'b0;
        bus.sel_A     = 1'b0;
        case (state)
            S_WAIT: begin
                bus.waiting = 1'b1;
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = S_DECODE;
                end
            end
            S_DECODE: begin
                if (is_mov_imm) begin
                    state_next = S_WR_IMM;
                end else if (is_mov_reg) begin
                    state_next = S_GET_B;
                end else if (is_alu) begin
                    state_next = S_GET_A;
                end else begin
                    set_illegal = 1'b1;
                    state_next  = S_WAIT;
                end
            end
            S_GET_A: begin
                bus.reg_sel = 2'b10;
                bus.en_A    = 1'b1;
                state_next  = S_GET_B;
            end
            S_GET_B: begin
                bus.en_B   = 1'b1;
                state_next = S_EXEC;
            end
            S_EXEC: begin
                // MOV Rd,Rm passes Rm through the ALU as 0 + B.
                bus.en_C      = 1'b1;
                bus.sel_A     = is_mov_reg;
                bus.en_status = is_cmp;
                if (is_cmp) begin
                    retire     = 1'b1;
                    state_next = S_WAIT;
                end else begin
                    state_next = S_WR_REG;
                end
            end
            S_WR_REG: begin
                bus.reg_sel = 2'b01;
                bus.w_en    = 1'b1;
                retire      = 1'b1;
                state_next  = S_WAIT;
            end
            S_WR_IMM: begin
                bus.reg_sel = 2'b10;
                bus.wb_sel  = 2'b10;
                bus.w_en    = 1'b1;
                retire      = 1'b1;
                state_next  = S_WAIT;
            end
            default: begin
                state_next = S_WAIT;
            end
        endcase
    end

    assign bus.sel_B   = 1'b0;
    assign bus.illegal = illegal_q;
    assign bus.retired = retired_q;
    assign dbg_state   = state;
endmodule

// File: tb/tb_sm_controller.sv
// Scoreboard bench for sm_controller: a per-instruction-class model queues the expected
// control word of every busy cycle plus the final status; a negedge monitor compares them.
module tb_sm_controller;
    localparam int CNT_W = 2;
    localparam int W     = 13 + CNT_W;
    localparam logic [CNT_W-1:0] RET_MAX = {CNT_W{1'b1}};

    logic       clk;
    logic       rst_n;
    logic [2:0] dbg_state;
    int         cyc;

    sm_controller_if #(.CNT_W(CNT_W)) bus ();

    sm_controller #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .bus       (bus),
        .dbg_state (dbg_state)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard state ----------------
    logic [W-1:0]     exp_q[$];
    logic [CNT_W:0]   stat_q[$];
    int               compared;
    int               mismatched;
    logic [CNT_W-1:0] m_ret;
    logic             m_ill;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] mk(input logic [1:0] rs, input logic [1:0] wb,
                                        input logic wen, input logic a, input logic b,
                                        input logic c, input logic st, input logic sa,
                                        input logic [CNT_W-1:0] ret);
        return {1'b0, rs, wb, wen, a, b, c, st, sa, 1'b0, 1'b0, ret};
    endfunction

    // Instruction classes from the ISA table, then the cycle-by-cycle control each one needs.
    task automatic push_instr(input logic [2:0] op, input logic [1:0] alu);
        logic [CNT_W-1:0] r;
        bit legal;
        r = m_ret;
        legal = 1'b1;
        exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 0, 0, 0, r));          // decode cycle
        if (op == 3'b110 && alu == 2'b10) begin                          // MOV Rn,#im8
            exp_q.push_back(mk(2'b10, 2'b10, 1, 0, 0, 0, 0, 0, r));
        end else if (op == 3'b110 && alu == 2'b00) begin                 // MOV Rd,Rm
            exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 1, 0, 0, 0, r));
            exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, 0, 1, r));
            exp_q.push_back(mk(2'b01, 2'b00, 1, 0, 0, 0, 0, 0, r));
        end else if (op == 3'b101) begin                                 // ALU group
            exp_q.push_back(mk(2'b10, 2'b00, 0, 1, 0, 0, 0, 0, r));
            exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 1, 0, 0, 0, r));
            exp_q.push_back(mk(2'b00, 2'b00, 0, 0, 0, 1, (alu == 2'b01), 0, r));
            if (alu != 2'b01) exp_q.push_back(mk(2'b01, 2'b00, 1, 0, 0, 0, 0, 0, r));
        end else begin
            legal = 1'b0;
        end
        if (legal) begin
            m_ill = 1'b0;
            if (m_ret != RET_MAX) m_ret = m_ret + 1'b1;
        end else begin
            m_ill = 1'b1;
        end
        stat_q.push_back({m_ill, m_ret});
    endtask

    // ---------------- monitor ----------------
    logic prev_waiting;
    logic [W-1:0] act_word;
    always @(negedge clk) begin
        act_word = {bus.waiting, bus.reg_sel, bus.wb_sel, bus.w_en, bus.en_A, bus.en_B,
                    bus.en_C, bus.en_status, bus.sel_A, bus.sel_B, bus.illegal, bus.retired};
        if (!rst_n) begin
            prev_waiting = 1'b1;
        end else if (!bus.waiting) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_busy", 32'(act_word), 32'(0));
            end else begin
                chk("busy_word", 32'(act_word), 32'(exp_q.pop_front()));
            end
            prev_waiting = 1'b0;
        end else begin
            chk("idle_ctl", 32'(act_word[W-1:CNT_W+1]), 32'h800);
            if (!prev_waiting) begin
                chk("early_done_left", exp_q.size(), 0);
                exp_q.delete();
                if (stat_q.size() == 0) begin
                    chk("stat_missing", 32'(act_word[CNT_W:0]), 32'hFFFF);
                end else begin
                    chk("done_ill_ret", 32'(act_word[CNT_W:0]), 32'(stat_q.pop_front()));
                end
            end
            prev_waiting = 1'b1;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic do_reset(input int n);
        bus.start = 1'b0;
        rst_n = 1'b0;
        exp_q.delete();
        stat_q.delete();
        m_ret = '0;
        m_ill = 1'b0;
        step(n);
        rst_n = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        while (!bus.waiting && n < 40) begin
            step(1);
            n++;
        end
        if (!bus.waiting) chk(name, 32'(bus.waiting), 32'd1);
    endtask

    task automatic issue(input logic [2:0] op, input logic [1:0] alu, input bit keep);
        wait_idle("issue_timeout");
        if (bus.waiting) begin
            bus.start  = 1'b1;
            bus.opcode = op;
            bus.ALU_op = alu;
            push_instr(op, alu);
            step(1);
            if (!keep) bus.start = 1'b0;
            bus.opcode = 3'($urandom_range(0, 7));
            bus.ALU_op = 2'($urandom_range(0, 3));
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        int c0;
        logic [2:0] op;
        logic [1:0] alu;
        bit keep;
        compared = 0;
        mismatched = 0;
        cyc = 0;
        prev_waiting = 1'b1;
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.opcode = 3'b000;
        bus.ALU_op = 2'b00;
        step(1);
        do_reset(2);
        step(1);
        chk("rst_waiting", 32'(bus.waiting), 32'd1);
        chk("rst_retired", 32'(bus.retired), 32'd0);
        chk("rst_illegal", 32'(bus.illegal), 32'd0);
        chk("rst_w_en", 32'(bus.w_en), 32'd0);

        // Directed: MOV R3,#-5 (D3FB), ADD (A140), CMP, AND, MVN, MOV Rd,Rm.
        issue(3'b110, 2'b10, 0);
        chk("movimm_decode_busy", 32'(bus.waiting), 32'd0);
        step(2);
        chk("movimm_done_after_2", 32'(bus.waiting), 32'd1);
        issue(3'b101, 2'b00, 0);
        issue(3'b101, 2'b01, 0);
        do_reset(1);
        issue(3'b101, 2'b10, 0);
        issue(3'b101, 2'b11, 0);
        issue(3'b110, 2'b00, 0);

        // Illegal then legal clears the flag.
        issue(3'b111, 2'b01, 0);
        wait_idle("ill_idle");
        step(1);
        chk("illegal_sticky", 32'(bus.illegal), 32'd1);
        issue(3'b011, 2'b10, 0);
        issue(3'b110, 2'b10, 0);
        wait_idle("ill_clear_idle");
        step(1);
        chk("illegal_cleared", 32'(bus.illegal), 32'd0);

        // Reset in the middle of an ADD, while B is being loaded.
        do_reset(1);
        issue(3'b101, 2'b00, 0);
        step(2);
        chk("midadd_at_get_b", 32'(bus.en_B), 32'd1);
        do_reset(1);
        chk("midadd_rst_waiting", 32'(bus.waiting), 32'd1);
        chk("midadd_rst_retired", 32'(bus.retired), 32'd0);
        step(1);
        chk("midadd_no_w_en", 32'(bus.w_en), 32'd0);

        // Back-to-back MOV imm with start held: retired 1,2,3,3,3 and no extra idle cycles.
        do_reset(1);
        c0 = cyc;
        for (int i = 0; i < 5; i++) issue(3'b110, 2'b10, (i < 4));
        wait_idle("b2b_idle");
        chk("b2b_cycles", 32'(cyc - c0), 32'd15);
        chk("b2b_retired_sat", 32'(bus.retired), 32'(RET_MAX));

        // Randomized mix with occasional resets and held start.
        do_reset(1);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 11) == 0) do_reset($urandom_range(1, 2));
            case ($urandom_range(0, 3))
                0: op = 3'b110;
                1, 2: op = 3'b101;
                default: op = 3'($urandom_range(0, 7));
            endcase
            alu = 2'($urandom_range(0, 3));
            keep = ($urandom_range(0, 2) == 0) && (i < 79);
            issue(op, alu, keep);
            if (!keep) step($urandom_range(0, 2));
        end

        wait_idle("final_idle");
        step(2);
        chk("final_exp_q_empty", exp_q.size(), 0);
        chk("final_stat_q_empty", stat_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
